// File: rtl/ysyx_24100005_wb_arbiter.sv
// rtl/ysyx_24100005_wb_arbiter.sv - write-back arbiter and register scoreboard
//
// Shares the register file's single write port between two producers with
// round-robin valid/ready arbitration, registers the winning write, and keeps
// a per-register busy scoreboard so decode can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req0_valid/ready/rd/data     EXU write-back request
//   req1_valid/ready/rd/data     LSU write-back request
//   iss_valid, iss_rd, iss_ready decode issue of an instruction with a destination
//   rs1addr/rs1_busy             source 1 pending-write query
//   rs2addr/rs2_busy             source 2 pending-write query
//   rf_wen, rf_waddr, rf_wdata   registered register-file write port
module ysyx_24100005_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_rd,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_rd,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] rs1addr,
  input  logic [ADDR_WIDTH-1:0] rs2addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;

  // last_grant: 0 = req0 won most recently, 1 = req1 won most recently.
  logic            last_grant;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            grant0;
  logic            grant1;

  // Round-robin: a lone requester always wins; on contention the one that
  // did not win last time goes first.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign iss_ready = (iss_rd == '0) || !busy[iss_rd];
  assign rs1_busy  = busy[rs1addr];
  assign rs2_busy  = busy[rs2addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else if (grant0) begin
      last_grant <= 1'b0;
      rf_wen     <= (req0_rd != '0);
      rf_waddr   <= req0_rd;
      rf_wdata   <= req0_data;
    end else if (grant1) begin
      last_grant <= 1'b1;
      rf_wen     <= (req1_rd != '0);
      rf_waddr   <= req1_rd;
      rf_wdata   <= req1_data;
    end else begin
      rf_wen     <= 1'b0;
    end
  end

  // Clear on the edge the register file commits, then apply a new issue so
  // that a same-edge set of the same index wins over the clear.
  always_comb begin
    busy_next = busy;
    if (rf_wen) begin
      busy_next[rf_waddr] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != '0)) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_wb_arbiter.sv
// tb/tb_ysyx_24100005_wb_arbiter.sv - self-checking bench for the write-back arbiter
module tb_ysyx_24100005_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rd, rs1addr, rs2addr;
  logic        rs1_busy, rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  ysyx_24100005_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1addr(rs1addr), .rs2addr(rs2addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state of the write port and scoreboard.
  bit          m_last = 1'b1;
  logic [31:0] m_busy = '0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  bit          pend0 = 1'b0;
  bit          pend1 = 1'b0;

  task automatic chk(input string tag, input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, name, obs, exp);
    end
  endtask

  // One clock cycle: check combinational outputs against the model, queue the
  // expected write-port state, advance the clock and check the popped entry.
  task automatic tick(input string tag);
    bit          g0, g1, exp_iss;
    wr_t         r;
    logic [31:0] nb;
    #1;
    assert (!(pend0 && !req0_valid) && !(pend1 && !req1_valid)) else begin
      n_err++;
      $error("FAIL %s.valid_drop: observed dropped expected held", tag);
    end
    g0 = req0_valid && (!req1_valid || m_last);
    g1 = req1_valid && (!req0_valid || !m_last);
    exp_iss = (iss_rd == 5'd0) || !m_busy[iss_rd];
    chk(tag, "req0_ready", 64'(req0_ready), 64'(g0));
    chk(tag, "req1_ready", 64'(req1_ready), 64'(g1));
    chk(tag, "iss_ready", 64'(iss_ready), 64'(exp_iss));
    chk(tag, "rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1addr]));
    chk(tag, "rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2addr]));
    if (rst) begin
      r = '{1'b0, 5'd0, 32'd0};
    end else if (g0) begin
      r = '{(req0_rd != 5'd0), req0_rd, req0_data};
    end else if (g1) begin
      r = '{(req1_rd != 5'd0), req1_rd, req1_data};
    end else begin
      r = '{1'b0, m_waddr, m_wdata};
    end
    sb.push_back(r);
    nb = m_busy;
    if (m_wen) nb[m_waddr] = 1'b0;
    if (iss_valid && exp_iss && (iss_rd != 5'd0)) nb[iss_rd] = 1'b1;
    nb[0] = 1'b0;
    if (rst) nb = '0;
    if (rst) m_last = 1'b1;
    else if (g0) m_last = 1'b0;
    else if (g1) m_last = 1'b1;
    pend0 = req0_valid && !g0 && !rst;
    pend1 = req1_valid && !g1 && !rst;
    @(posedge clk);
    #1;
    r = sb.pop_front();
    chk(tag, "rf_wen", 64'(rf_wen), 64'(r.wen));
    chk(tag, "rf_waddr", 64'(rf_waddr), 64'(r.addr));
    chk(tag, "rf_wdata", 64'(rf_wdata), 64'(r.data));
    m_wen = r.wen;
    m_waddr = r.addr;
    m_wdata = r.data;
    m_busy = nb;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1addr = '0; rs2addr = '0;
    @(posedge clk);
    #1;
    tick("reset0");
    tick("reset1");
    rst = 1'b0;
    tick("idle");

    // Single write to x5 with RAW visibility until the commit edge.
    iss_valid = 1'b1; iss_rd = 5'd5; rs1addr = 5'd5;
    tick("iss5");
    iss_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    tick("wr5_accept");
    req0_valid = 1'b0;
    tick("wr5_commit");
    tick("wr5_clear");

    // Write to x0 is accepted but produces no write.
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234; rs1addr = 5'd0;
    tick("x0_accept");
    req1_valid = 1'b0;
    tick("x0_after");

    // Contention: grants alternate 0,1,0,1.
    req0_rd = 5'd10; req0_data = 32'hA0A0_0010;
    req1_rd = 5'd11; req1_data = 32'hB1B1_0011;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      tick("contend");
    end
    req1_valid = 1'b0;
    tick("contend_tail");
    req0_valid = 1'b0;
    tick("contend_drain");

    // WAW stall on x7, reissue once the commit has cleared it.
    iss_valid = 1'b1; iss_rd = 5'd7; rs2addr = 5'd7;
    tick("iss7");
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h0000_0077;
    tick("waw_accept");
    req0_valid = 1'b0;
    tick("waw_commit");
    tick("waw_reissue");
    iss_valid = 1'b0;
    tick("waw_busy");
    req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h0000_0777;
    tick("x7_second");
    req1_valid = 1'b0;
    tick("x7_commit");
    tick("x7_clear");

    // Back-to-back throughput, one write per cycle.
    for (int i = 1; i <= 8; i++) begin
      req0_valid = 1'b1; req0_rd = 5'(i); req0_data = 32'hC000_0000 + 32'(i);
      tick("b2b");
    end
    req0_valid = 1'b0;
    tick("b2b_drain");

    // Reset while a write to x3 is in flight.
    iss_valid = 1'b1; iss_rd = 5'd3; rs1addr = 5'd3;
    tick("iss3");
    iss_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h0000_0033;
    tick("wr3_accept");
    req0_valid = 1'b0;
    rst = 1'b1;
    tick("rst_mid");
    rst = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 32'h2222_2222;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h4444_4444;
    tick("post_rst_contend");
    req0_valid = 1'b0;
    tick("post_rst_req1");
    req1_valid = 1'b0;
    tick("post_rst_drain");
    tick("post_rst_idle");

    chk("end", "queue_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
